fighter_anim_ctrl: RTL

FIGHTER_ANIM_CTRL -- requirements
Module: fighter_anim_ctrl

---
 rtl/fighter_anim_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fighter_anim_ctrl.sv
// fighter_anim_ctrl: frame-tick driven animation state machine for a fighter
// sprite (idle/walk/jump/two attacks/hitstun/KO). Button presses are edge
// detected every clk into pending bits; state only advances on frame_tick.
// Optional macro FIGHTER_ANIM_CHAIN_EN: an atk2 press during ATK1 chains
// directly into ATK2 when ATK1 completes.
module fighter_anim_ctrl #(
    parameter int TICKS_PER_FRAME = 4,
    parameter int ATK1_FRAMES     = 5,
    parameter int ATK2_FRAMES     = 7,
    parameter int JUMP_TICKS      = 30,
    parameter int HITSTUN_TICKS   = 20,
    parameter int ACT_START       = 2,
    parameter int ACT_END         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_l,
    input  logic       move_r,
    input  logic       jump_btn,
    input  logic       atk1_btn,
    input  logic       atk2_btn,
    input  logic       hit_in,
    input  logic       ko_in,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       busy,
    output logic       attack_active,
    output logic       anim_done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WALK = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5,
        S_LOSE = 4'd6
    } state_t;

    localparam logic [3:0] SUB_LAST  = 4'(TICKS_PER_FRAME - 1);
    localparam logic [5:0] ATK1_LAST = 6'(ATK1_FRAMES - 1);
    localparam logic [5:0] ATK2_LAST = 6'(ATK2_FRAMES - 1);
    localparam logic [7:0] JUMP_LD   = 8'(JUMP_TICKS - 1);
    localparam logic [7:0] HIT_LD    = 8'(HITSTUN_TICKS - 1);
    localparam logic [5:0] ACT_LO    = 6'(ACT_START);
    localparam logic [5:0] ACT_HI    = 6'(ACT_END);

    state_t     state, state_nxt, rest_state;
    logic [5:0] frame, frame_nxt;
    logic [3:0] sub, sub_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       done_nxt, busy_nxt, act_nxt;

    logic jump_hist, atk1_hist, atk2_hist;
    logic jump_pend, atk1_pend, atk2_pend, hit_pend;
    logic jump_req, atk1_req, atk2_req, hit_req;

    // A press whose edge lands on the tick cycle itself still counts for that tick.
    assign jump_req   = jump_pend | (jump_btn & ~jump_hist);
    assign atk1_req   = atk1_pend | (atk1_btn & ~atk1_hist);
    assign atk2_req   = atk2_pend | (atk2_btn & ~atk2_hist);
    assign hit_req    = hit_pend | hit_in;
    assign rest_state = (move_l ^ move_r) ? S_WALK : S_IDLE;

`ifdef FIGHTER_ANIM_CHAIN_EN
    logic chain, chain_nxt;
`endif

    // Edge-detect history and sticky pending bits; every tick clears the pending set.
    always_ff @(posedge clk) begin
        jump_hist <= jump_btn;
        atk1_hist <= atk1_btn;
        atk2_hist <= atk2_btn;
        if (!rst_n || frame_tick) begin
            jump_pend <= 1'b0;
            atk1_pend <= 1'b0;
            atk2_pend <= 1'b0;
            hit_pend  <= 1'b0;
        end else begin
            jump_pend <= jump_req;
            atk1_pend <= atk1_req;
            atk2_pend <= atk2_req;
            hit_pend  <= hit_req;
        end
    end

    // State/counter/output registers; advance only on frame_tick, done is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            frame         <= '0;
            sub           <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            attack_active <= 1'b0;
            anim_done     <= 1'b0;
`ifdef FIGHTER_ANIM_CHAIN_EN
            chain         <= 1'b0;
`endif
        end else begin
            anim_done <= frame_tick & done_nxt;
            if (frame_tick) begin
                state         <= state_nxt;
                frame         <= frame_nxt;
                sub           <= sub_nxt;
                cnt           <= cnt_nxt;
                busy          <= busy_nxt;
                attack_active <= act_nxt;
`ifdef FIGHTER_ANIM_CHAIN_EN
                chain         <= chain_nxt;
`endif
            end
        end
    end

    // Tick transition: ko > hit > busy continuation > atk1 > atk2 > jump > walk/idle.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame;
        sub_nxt   = sub;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
`ifdef FIGHTER_ANIM_CHAIN_EN
        chain_nxt = chain;
`endif
        if (state == S_LOSE) begin
            frame_nxt = '0;
        end else if (ko_in) begin
            state_nxt = S_LOSE;
            frame_nxt = '0;
`ifdef FIGHTER_ANIM_CHAIN_EN
            chain_nxt = 1'b0;
`endif
        end else if (hit_req) begin
            state_nxt = S_HIT;
            frame_nxt = '0;
            cnt_nxt   = HIT_LD;
`ifdef FIGHTER_ANIM_CHAIN_EN
            chain_nxt = 1'b0;
`endif
        end else begin
            case (state)
                S_JUMP, S_HIT: begin
                    if (cnt == 8'd0) begin
                        state_nxt = rest_state;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_ATK1, S_ATK2: begin
                    if (sub == SUB_LAST) begin
                        sub_nxt = '0;
                        if (frame == ((state == S_ATK1) ? ATK1_LAST : ATK2_LAST)) begin
                            done_nxt  = 1'b1;
                            frame_nxt = '0;
`ifdef FIGHTER_ANIM_CHAIN_EN
                            if (state == S_ATK1 && (chain || atk2_req))
                                state_nxt = S_ATK2;
                            else
                                state_nxt = rest_state;
                            chain_nxt = 1'b0;
`else
                            state_nxt = rest_state;
`endif
                        end else begin
                            frame_nxt = frame + 6'd1;
`ifdef FIGHTER_ANIM_CHAIN_EN
                            if (state == S_ATK1) chain_nxt = chain | atk2_req;
`endif
                        end
                    end else begin
                        sub_nxt = sub + 4'd1;
`ifdef FIGHTER_ANIM_CHAIN_EN
                        if (state == S_ATK1) chain_nxt = chain | atk2_req;
`endif
                    end
                end
                default: begin
                    frame_nxt = '0;
                    sub_nxt   = '0;
                    if (atk1_req) begin
                        state_nxt = S_ATK1;
                    end else if (atk2_req) begin
                        state_nxt = S_ATK2;
                    end else if (jump_req) begin
                        state_nxt = S_JUMP;
                        cnt_nxt   = JUMP_LD;
                    end else begin
                        state_nxt = rest_state;
                    end
                end
            endcase
        end
    end

    // Registered flag values derived from the state being entered.
    always_comb begin
        busy_nxt = (state_nxt == S_JUMP) || (state_nxt == S_ATK1) || (state_nxt == S_ATK2) ||
                   (state_nxt == S_HIT) || (state_nxt == S_LOSE);
        act_nxt  = ((state_nxt == S_ATK1) || (state_nxt == S_ATK2)) &&
                   (frame_nxt >= ACT_LO) && (frame_nxt <= ACT_HI);
    end

    assign anim_state = state;
    assign anim_frame = frame;

endmodule
